// File: rtl/key_event_queue.sv
// key_event_queue: latches one-cycle key press pulses into a pending set,
// grants the lowest-index pending key each cycle into a small
// first-word-fall-through FIFO, and drains the FIFO with a valid/ready
// handshake. A press that lands on a key that is still pending is merged
// into the earlier press and raises the sticky OVERFLOW flag.
module key_event_queue #(
  parameter int N_KEYS = 8,
  parameter int CODE_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                         CLK,
  input  logic                         ACLR,
  input  logic [N_KEYS-1:0]            KEY_PULSE,
  output logic [CODE_W-1:0]            KEY_CODE,
  output logic                         KEY_VALID,
  input  logic                         KEY_READY,
  output logic [N_KEYS-1:0]            PENDING,
  output logic [$clog2(DEPTH):0]       COUNT,
  output logic                         OVERFLOW,
  input  logic                         CLR_OVF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] ONE_PTR  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [N_KEYS-1:0] pending_r;
  logic [CODE_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;

  logic [N_KEYS-1:0] grant_vec_s;
  logic [N_KEYS-1:0] grant_eff_s;
  logic [CODE_W-1:0] grant_idx_s;
  logic              found_s;
  logic              push_s;
  logic              pop_s;
  logic              merge_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [CODE_W-1:0] key_code_s;

  // Lowest-index pending key wins the grant.
  always_comb begin
    grant_vec_s = {N_KEYS{1'b0}};
    grant_idx_s = {CODE_W{1'b0}};
    found_s     = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (pending_r[i] && !found_s) begin
        grant_vec_s[i] = 1'b1;
        grant_idx_s    = CODE_W'(i);
        found_s        = 1'b1;
      end else begin
        grant_vec_s[i] = 1'b0;
      end
    end
  end

  // Push is decided on the start-of-cycle count only, so a same-cycle pop
  // never frees room for a push into a full FIFO.
  always_comb begin
    push_s = found_s && (count_r != FULL_CNT);
    if (push_s) begin
      grant_eff_s = grant_vec_s;
    end else begin
      grant_eff_s = {N_KEYS{1'b0}};
    end
    pop_s   = (count_r != ZERO_CNT) && KEY_READY;
    merge_s = |(KEY_PULSE & pending_r & ~grant_eff_s);
  end

  // Occupancy bookkeeping for simultaneous push and pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_CNT;
      2'b01:   count_next_s = count_r - ONE_CNT;
      default: count_next_s = count_r;
    endcase
  end

  // Head decode; the code reads as zero whenever the FIFO is empty.
  always_comb begin
    if (count_r != ZERO_CNT) begin
      key_code_s = mem_r[rd_ptr_r];
    end else begin
      key_code_s = {CODE_W{1'b0}};
    end
  end

  // Pending set, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      pending_r  <= {N_KEYS{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= ZERO_CNT;
      overflow_r <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~grant_eff_s) | KEY_PULSE;
      count_r   <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      // A merge in the same cycle as a clear keeps the flag set.
      if (merge_s) begin
        overflow_r <= 1'b1;
      end else if (CLR_OVF) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // FIFO storage; contents are don't-care while their slot is empty.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= grant_idx_s;
    end
  end

  assign KEY_CODE  = key_code_s;
  assign KEY_VALID = (count_r != ZERO_CNT);
  assign PENDING   = pending_r;
  assign COUNT     = count_r;
  assign OVERFLOW  = overflow_r;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: expected key codes are queued when the
// presses are driven and compared whenever the bench accepts the FIFO head.
module tb_key_event_queue;

  logic       CLK;
  logic       ACLR;
  logic [7:0] KEY_PULSE;
  logic [2:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_READY;
  logic [7:0] PENDING;
  logic [2:0] COUNT;
  logic       OVERFLOW;
  logic       CLR_OVF;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb [$];

  key_event_queue #(.N_KEYS(8), .CODE_W(3), .DEPTH(4)) dut (
    .CLK       (CLK),
    .ACLR      (ACLR),
    .KEY_PULSE (KEY_PULSE),
    .KEY_CODE  (KEY_CODE),
    .KEY_VALID (KEY_VALID),
    .KEY_READY (KEY_READY),
    .PENDING   (PENDING),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .CLR_OVF   (CLR_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare an accepted head against the scoreboard, then advance one edge.
  task automatic tick();
    logic [2:0] exp_code;
    if (KEY_VALID && KEY_READY) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'(KEY_CODE), 32'hFFFF_FFFF);
      end else begin
        exp_code = sb.pop_front();
        check("pop_code", 32'(KEY_CODE), 32'(exp_code));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    ACLR      = 1'b1;
    KEY_PULSE = 8'h00;
    KEY_READY = 1'b0;
    CLR_OVF   = 1'b0;
    ticks(2);
    ACLR = 1'b0;
    tick();
    check("rst_valid",   32'(KEY_VALID), 32'd0);
    check("rst_code",    32'(KEY_CODE),  32'd0);
    check("rst_count",   32'(COUNT),     32'd0);
    check("rst_pending", 32'(PENDING),   32'd0);
    check("rst_ovf",     32'(OVERFLOW),  32'd0);

    // Single press into an empty queue: two-edge latency.
    KEY_READY = 1'b1;
    KEY_PULSE = 8'h04;
    sb.push_back(3'd2);
    tick();
    KEY_PULSE = 8'h00;
    check("single_pending", 32'(PENDING),   32'h04);
    check("single_valid0",  32'(KEY_VALID), 32'd0);
    tick();
    check("single_valid",   32'(KEY_VALID), 32'd1);
    check("single_code",    32'(KEY_CODE),  32'd2);
    check("single_count",   32'(COUNT),     32'd1);
    tick();
    check("single_count0",  32'(COUNT),     32'd0);
    check("single_valid1",  32'(KEY_VALID), 32'd0);

    // Simultaneous presses enqueue in priority order.
    KEY_READY = 1'b0;
    KEY_PULSE = 8'h91;
    sb.push_back(3'd0); sb.push_back(3'd4); sb.push_back(3'd7);
    tick();
    KEY_PULSE = 8'h00;
    check("simul_pending", 32'(PENDING), 32'h91);
    tick(); check("simul_count1", 32'(COUNT), 32'd1);
    tick(); check("simul_count2", 32'(COUNT), 32'd2);
    tick(); check("simul_count3", 32'(COUNT), 32'd3);
    KEY_READY = 1'b1;
    ticks(3);
    check("simul_drained", 32'(COUNT), 32'd0);
    check("simul_sb",      32'(sb.size()), 32'd0);

    // Back-pressure: keys 0..5, one per cycle, with the consumer stalled.
    KEY_READY = 1'b0;
    for (int k = 0; k < 6; k++) begin
      KEY_PULSE = 8'h01 << k;
      sb.push_back(3'(k));
      tick();
    end
    KEY_PULSE = 8'h00;
    tick();
    check("full_count",   32'(COUNT),    32'd4);
    check("full_pending", 32'(PENDING),  32'h30);
    check("full_ovf",     32'(OVERFLOW), 32'd0);

    // Merge loss: key 5 again while still pending.
    KEY_PULSE = 8'h20;
    tick();
    KEY_PULSE = 8'h00;
    check("merge_ovf",     32'(OVERFLOW), 32'd1);
    check("merge_pending", 32'(PENDING),  32'h30);
    KEY_READY = 1'b1;
    ticks(8);
    check("merge_drained", 32'(COUNT),    32'd0);
    check("merge_pend0",   32'(PENDING),  32'h00);
    check("merge_sb",      32'(sb.size()), 32'd0);
    check("merge_ovf_hold", 32'(OVERFLOW), 32'd1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check("clr_ovf", 32'(OVERFLOW), 32'd0);

    // Push and pop together at COUNT=2.
    KEY_READY = 1'b0;
    KEY_PULSE = 8'h03;
    sb.push_back(3'd0); sb.push_back(3'd1);
    tick();
    KEY_PULSE = 8'h00;
    ticks(2);
    check("pp_count2", 32'(COUNT), 32'd2);
    KEY_PULSE = 8'h08;
    sb.push_back(3'd3);
    tick();
    KEY_PULSE = 8'h00;
    check("pp_pending", 32'(PENDING), 32'h08);
    KEY_READY = 1'b1;
    tick();
    check("pp_count_same", 32'(COUNT), 32'd2);
    ticks(3);
    check("pp_drained", 32'(COUNT), 32'd0);
    check("pp_sb",      32'(sb.size()), 32'd0);

    // Pop from a full FIFO delays the next push by one cycle.
    KEY_READY = 1'b0;
    KEY_PULSE = 8'h1F;
    for (int k = 0; k < 5; k++) sb.push_back(3'(k));
    tick();
    KEY_PULSE = 8'h00;
    ticks(4);
    check("fp_count4",   32'(COUNT),   32'd4);
    check("fp_pending",  32'(PENDING), 32'h10);
    KEY_READY = 1'b1;
    tick();
    check("fp_count3",   32'(COUNT),   32'd3);
    check("fp_pend_hold", 32'(PENDING), 32'h10);
    KEY_READY = 1'b0;
    tick();
    check("fp_count4b",  32'(COUNT),   32'd4);
    check("fp_pend0",    32'(PENDING), 32'h00);
    KEY_READY = 1'b1;
    ticks(5);
    check("fp_drained",  32'(COUNT),   32'd0);
    check("fp_sb",       32'(sb.size()), 32'd0);

    // Asynchronous reset mid-stream discards everything.
    KEY_READY = 1'b0;
    KEY_PULSE = 8'h0D;
    tick();
    KEY_PULSE = 8'h00;
    ticks(3);
    KEY_PULSE = 8'h02;
    tick();
    KEY_PULSE = 8'h00;
    check("mid_count",   32'(COUNT),   32'd3);
    check("mid_pending", 32'(PENDING), 32'h02);
    #2;
    ACLR = 1'b1;
    #1;
    check("arst_valid",   32'(KEY_VALID), 32'd0);
    check("arst_code",    32'(KEY_CODE),  32'd0);
    check("arst_count",   32'(COUNT),     32'd0);
    check("arst_pending", 32'(PENDING),   32'd0);
    check("arst_ovf",     32'(OVERFLOW),  32'd0);
    tick();
    ACLR = 1'b0;
    KEY_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_rst_idle", 32'(KEY_VALID), 32'd0);
    end
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Collects the one-cycle press pulses produced by the per-button debouncers and turns them into an ordered stream of key codes for the control logic. Presses on any buttons, including simultaneous ones, are latched into a pending set, encoded by priority, and buffered in a small first-word-fall-through FIFO. A valid/ready handshake drains the FIFO. The block sits between the debouncer bank and the top-level state machine, so downstream logic reads one key event at a time.

## Interface
Parameters:
- N_KEYS, default 8: number of debounced key inputs.
- CODE_W, default 3: key code width. 2^CODE_W >= N_KEYS.
- DEPTH, default 4: FIFO entries. Must be a power of 2, >= 2.

Ports:
- CLK  in  1  system clock, the same divided clock that feeds the debouncers.
- ACLR  in  1  asynchronous, active-high reset.
- KEY_PULSE  in  N_KEYS  one-cycle press pulses, bit i = key i.
- KEY_CODE  out  CODE_W  index of the key at the FIFO head. It is 0 when KEY_VALID=0.
- KEY_VALID  out  1  FIFO head holds an event.
- KEY_READY  in  1  consumer accepts the head this cycle.
- PENDING  out  N_KEYS  keys that are latched but not yet enqueued.
- COUNT  out  log2(DEPTH)+1  number of FIFO entries.
- OVERFLOW  out  1  sticky flag: a press was merged and therefore lost.
- CLR_OVF  in  1  synchronous clear of OVERFLOW.

## Operation
- Reset (ACLR=1, takes effect immediately): PENDING=0, FIFO empty, COUNT=0, KEY_VALID=0, KEY_CODE=0, OVERFLOW=0.
- Grant: when PENDING!=0 and COUNT<DEPTH, the lowest-index pending bit is granted. Its index is written to the FIFO tail and its PENDING bit is cleared. At most one grant per cycle.
- Pending update: PENDING_next = (PENDING & ~grant) | KEY_PULSE.
  - A pulse on the key being granted in the same cycle re-sets that key's bit. This counts as a new event.
- Merge/loss: if KEY_PULSE[i] & PENDING[i] & ~grant[i], the earlier press is already pending, the new one is merged and lost, and OVERFLOW is set.
  - OVERFLOW set has priority over CLR_OVF in the same cycle.
- Full: when COUNT==DEPTH, no grant occurs and presses stay in PENDING. A full FIFO alone never sets OVERFLOW.
- Pop: occurs when KEY_VALID & KEY_READY. The head advances on the clock edge.
- Push and pop in the same cycle:
  - Both occur and COUNT is unchanged.
  - A push is decided on COUNT at the start of the cycle. When COUNT==DEPTH, a same-cycle pop does not enable a push; the push happens one cycle later.
- Pointers wrap modulo DEPTH. COUNT is a separate counter, range 0..DEPTH.
- KEY_READY while KEY_VALID=0 is ignored.

## Timing
- A KEY_PULSE sampled at edge t sets PENDING after edge t.
  - If the FIFO is not full and no lower-index key is pending, the grant occurs at edge t+1.
  - KEY_VALID=1 and the correct KEY_CODE follow edge t+1. Latency is 2 cycles when the FIFO is empty.
- Drain rate: one event per cycle with KEY_READY held at 1.
- KEY_CODE and KEY_VALID are registered outputs, or decode of registered state only. They have no combinational path from KEY_READY or KEY_PULSE.
- COUNT, PENDING and OVERFLOW update on the CLK rising edge and reflect post-edge state.
- ACLR asserted mid-stream discards all queued and pending events. After release, nothing is emitted until a new pulse arrives.

## Test plan
- Single press, empty queue:
  - Stimulus: after reset, KEY_PULSE=8'h04 for 1 cycle, KEY_READY=1.
  - Response: KEY_VALID=1 and KEY_CODE=2 two edges later with COUNT=1. After one more edge, COUNT=0 and KEY_VALID=0.
- Simultaneous presses:
  - Stimulus: KEY_PULSE=8'h91 for 1 cycle, KEY_READY=0.
  - Response: COUNT goes 1, 2, 3 on consecutive edges. With KEY_READY=1 afterward, the output sequence is codes 0, 4, 7.
- Full FIFO back-pressure:
  - Stimulus: KEY_READY=0, pulses on keys 0..5, one per cycle.
  - Response: COUNT saturates at 4, PENDING=8'h30, OVERFLOW=0. Raising KEY_READY drains codes 0,1,2,3,4,5 in order.
- Merge loss:
  - Stimulus: in the full state with key 5 pending, pulse key 5 again.
  - Response: OVERFLOW=1 on the next edge. The queue later yields only one code 5. CLR_OVF for 1 cycle returns OVERFLOW to 0.
- Push and pop together:
  - Stimulus: COUNT=2, KEY_READY=1, a new pulse granted in the same cycle.
  - Response: COUNT stays 2 and head order is preserved. Repeat at COUNT=4 with a pop: the push is delayed one cycle, and COUNT goes 4 → 3 → 4.
- Reset mid-operation:
  - Stimulus: COUNT=3, PENDING=8'h02, assert ACLR asynchronously between edges.
  - Response: all outputs are 0 immediately. After release, KEY_VALID stays 0 for 10 cycles with no pulses.
